// File: rtl/frame_hdr_pkg.sv
// Shared types and constants for the frame header stripper.
package frame_hdr_pkg;

   typedef enum logic {
      StHdr,
      StPayload
   } state_t;

   localparam int unsigned DEFAULT_DW     = 512;
   localparam int unsigned DEFAULT_KEEP_W = DEFAULT_DW / 8;
   localparam int unsigned BYTE_CNT_W     = 32;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-stream output register: holds VALID and data until READY.
module axis_out_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic         free,
   output logic         valid,
   output logic [W-1:0] data,
   input  logic         ready
);

   logic         valid_q;
   logic [W-1:0] data_q;

   assign free  = !valid_q || ready;
   assign valid = valid_q;
   assign data  = data_q;

   // load is only raised by the parent while free is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= load_data;
      end else if (ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/frame_header_stripper.sv
// Splits each framed AXI-stream input into one metadata beat (header) and a payload stream,
// checking the payload byte count against the FRAME_SIZE latched with the header.
module frame_header_stripper
   import frame_hdr_pkg::*;
#(
   parameter int unsigned DW = DEFAULT_DW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BYTE_CNT_W-1:0] FRAME_SIZE,
   input  logic [DW-1:0]         AXIS_IN_TDATA,
   input  logic                  AXIS_IN_TVALID,
   input  logic [DW/8-1:0]       AXIS_IN_TKEEP,
   input  logic                  AXIS_IN_TLAST,
   output logic                  AXIS_IN_TREADY,
   output logic [DW-1:0]         AXIS_OUT_MD_TDATA,
   output logic                  AXIS_OUT_MD_TVALID,
   output logic                  AXIS_OUT_MD_TLAST,
   input  logic                  AXIS_OUT_MD_TREADY,
   output logic [DW-1:0]         AXIS_OUT_TDATA,
   output logic                  AXIS_OUT_TVALID,
   output logic [DW/8-1:0]       AXIS_OUT_TKEEP,
   output logic                  AXIS_OUT_TLAST,
   input  logic                  AXIS_OUT_TREADY,
   output logic                  ERR_LENGTH
);

   localparam int unsigned KW = DW / 8;

   state_t                  state_q, state_d;
   logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
   logic [BYTE_CNT_W-1:0]   fs_q, fs_d;
   logic                    err_q, err_d;

   logic                    md_free, pl_free;
   logic                    in_ready, accept, md_load, pl_load;
   logic [BYTE_CNT_W-1:0]   pop;
   logic [BYTE_CNT_W:0]     sum;
   logic [BYTE_CNT_W-1:0]   cnt_sat;

   assign in_ready       = !reset && ((state_q == StHdr) ? md_free : pl_free);
   assign AXIS_IN_TREADY = in_ready;
   assign accept         = AXIS_IN_TVALID && in_ready;
   assign md_load        = accept && (state_q == StHdr);
   assign pl_load        = accept && (state_q == StPayload);
   assign ERR_LENGTH     = err_q;

   always_comb begin
      pop = '0;
      for (int i = 0; i < KW; i++) begin
         pop = pop + {{(BYTE_CNT_W-1){1'b0}}, AXIS_IN_TKEEP[i]};
      end
   end

   assign sum     = {1'b0, cnt_q} + {1'b0, pop};
   assign cnt_sat = sum[BYTE_CNT_W] ? '1 : sum[BYTE_CNT_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fs_d    = fs_q;
      err_d   = 1'b0;
      case (state_q)
         StHdr: begin
            if (accept) begin
               fs_d  = FRAME_SIZE;
               cnt_d = '0;
               // an empty frame is complete on its header beat
               if (AXIS_IN_TLAST) err_d = (FRAME_SIZE != '0);
               else               state_d = StPayload;
            end
         end
         StPayload: begin
            if (accept) begin
               cnt_d = cnt_sat;
               if (AXIS_IN_TLAST) begin
                  state_d = StHdr;
                  err_d   = (cnt_sat != fs_q);
               end
            end
         end
         default: state_d = StHdr;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StHdr;
         cnt_q   <= '0;
         fs_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fs_q    <= fs_d;
         err_q   <= err_d;
      end
   end

   axis_out_reg #(
      .W (DW + 1)
   ) u_md_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (md_load),
      .load_data ({1'b1, AXIS_IN_TDATA}),
      .free      (md_free),
      .valid     (AXIS_OUT_MD_TVALID),
      .data      ({AXIS_OUT_MD_TLAST, AXIS_OUT_MD_TDATA}),
      .ready     (AXIS_OUT_MD_TREADY)
   );

   axis_out_reg #(
      .W (DW + KW + 1)
   ) u_pl_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (pl_load),
      .load_data ({AXIS_IN_TLAST, AXIS_IN_TKEEP, AXIS_IN_TDATA}),
      .free      (pl_free),
      .valid     (AXIS_OUT_TVALID),
      .data      ({AXIS_OUT_TLAST, AXIS_OUT_TKEEP, AXIS_OUT_TDATA}),
      .ready     (AXIS_OUT_TREADY)
   );

endmodule

// File: tb/tb_frame_header_stripper.sv
// Directed bench for frame_header_stripper with scoreboard queues for MD, payload and errors.
module tb_frame_header_stripper;

   localparam int unsigned DW = 512;
   localparam int unsigned KW = DW / 8;
   localparam logic [KW-1:0] KEEP_FULL = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [KW-1:0] KEEP_36   = 64'h0000_000F_FFFF_FFFF;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } pl_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   frame_size = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic [KW-1:0] in_keep = '0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [DW-1:0] md_data;
   logic          md_valid, md_last;
   logic          md_ready = 1'b1;
   logic [DW-1:0] pl_data;
   logic          pl_valid;
   logic [KW-1:0] pl_keep;
   logic          pl_last;
   logic          pl_ready = 1'b1;
   logic          err;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic [DW-1:0] md_q[$];
   pl_t           pl_q[$];
   int            err_q[$];

   // model state
   bit            m_hdr = 1'b1;
   logic [31:0]   m_fs = '0;
   logic [31:0]   m_cnt = '0;

   // stimulus knobs for the background ready drivers
   bit            tog_en = 1'b0;
   logic          pl_ready_cfg = 1'b1;
   int            md_stall_until = 0;

   frame_header_stripper #(
      .DW (DW)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .FRAME_SIZE         (frame_size),
      .AXIS_IN_TDATA      (in_data),
      .AXIS_IN_TVALID     (in_valid),
      .AXIS_IN_TKEEP      (in_keep),
      .AXIS_IN_TLAST      (in_last),
      .AXIS_IN_TREADY     (in_ready),
      .AXIS_OUT_MD_TDATA  (md_data),
      .AXIS_OUT_MD_TVALID (md_valid),
      .AXIS_OUT_MD_TLAST  (md_last),
      .AXIS_OUT_MD_TREADY (md_ready),
      .AXIS_OUT_TDATA     (pl_data),
      .AXIS_OUT_TVALID    (pl_valid),
      .AXIS_OUT_TKEEP     (pl_keep),
      .AXIS_OUT_TLAST     (pl_last),
      .AXIS_OUT_TREADY    (pl_ready),
      .ERR_LENGTH         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      pl_ready = tog_en ? ~pl_ready : pl_ready_cfg;
      md_ready = (cyc >= md_stall_until);
   end

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [31:0] popcnt(input logic [KW-1:0] k);
      logic [31:0] p = '0;
      for (int i = 0; i < KW; i++) p = p + {31'd0, k[i]};
      return p;
   endfunction

   // Monitor: handshakes, stability under stall, error pulse timing, reset outputs.
   logic          md_hold = 1'b0, pl_hold = 1'b0;
   logic [DW-1:0] md_held;
   pl_t           pl_held, pl_exp;
   logic [DW-1:0] md_exp;
   int            err_exp;

   always @(negedge clk) begin
      if (reset) begin
         checks++;
         assert ({md_valid, pl_valid, md_last, pl_last, err, in_ready} === 6'b0) else begin
            failures++;
            $error("FAIL reset_outputs got=%b exp=000000",
                   {md_valid, pl_valid, md_last, pl_last, err, in_ready});
         end
         md_hold = 1'b0;
         pl_hold = 1'b0;
      end else begin
         if (md_hold) begin
            checks++;
            assert (md_valid === 1'b1 && md_data === md_held) else begin
               failures++;
               $error("FAIL md_stable got=%b/%h exp=1/%h", md_valid, md_data, md_held);
            end
         end
         if (md_valid && md_ready) begin
            checks++;
            assert (md_q.size() != 0) else begin
               failures++;
               $error("FAIL md_unexpected got=beat exp=none");
            end
            if (md_q.size() != 0) begin
               md_exp = md_q.pop_front();
               checks++;
               assert (md_data === md_exp && md_last === 1'b1) else begin
                  failures++;
                  $error("FAIL md_beat got=%h/%b exp=%h/1", md_data, md_last, md_exp);
               end
            end
         end
         md_hold = md_valid && !md_ready;
         md_held = md_data;

         if (pl_hold) begin
            checks++;
            assert (pl_valid === 1'b1 && pl_data === pl_held.data && pl_keep === pl_held.keep
                    && pl_last === pl_held.last) else begin
               failures++;
               $error("FAIL pl_stable got=%b/%h exp=1/%h", pl_valid, pl_data, pl_held.data);
            end
         end
         if (pl_valid && pl_ready) begin
            checks++;
            assert (pl_q.size() != 0) else begin
               failures++;
               $error("FAIL pl_unexpected got=%h exp=none", pl_data);
            end
            if (pl_q.size() != 0) begin
               pl_exp = pl_q.pop_front();
               checks++;
               assert (pl_data === pl_exp.data) else begin
                  failures++;
                  $error("FAIL pl_data got=%h exp=%h", pl_data, pl_exp.data);
               end
               checks++;
               assert (pl_keep === pl_exp.keep && pl_last === pl_exp.last) else begin
                  failures++;
                  $error("FAIL pl_keep_last got=%h/%b exp=%h/%b",
                         pl_keep, pl_last, pl_exp.keep, pl_exp.last);
               end
            end
         end
         pl_hold         = pl_valid && !pl_ready;
         pl_held.data    = pl_data;
         pl_held.keep    = pl_keep;
         pl_held.last    = pl_last;

         if (err) begin
            err_exp = (err_q.size() != 0) ? err_q.pop_front() : -1;
            checks++;
            assert (err_exp == cyc) else begin
               failures++;
               $error("FAIL err_pulse got=cycle%0d exp=cycle%0d", cyc, err_exp);
            end
         end
      end
   end

   // Drive one beat, wait (bounded) for acceptance, update the model; returns the accept edge.
   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                       input logic [31:0] fs, output int acc_cyc);
      logic [32:0] s;
      bit          acc = 1'b0;
      pl_t         e;
      in_data    = d;
      in_keep    = k;
      in_last    = l;
      frame_size = fs;
      in_valid   = 1'b1;
      acc_cyc    = -1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (in_ready) begin
            acc     = 1'b1;
            acc_cyc = cyc + 1;
            if (m_hdr) begin
               md_q.push_back(d);
               m_fs  = fs;
               m_cnt = '0;
               if (l) begin
                  if (fs != 0) err_q.push_back(acc_cyc);
               end else begin
                  m_hdr = 1'b0;
               end
            end else begin
               e.data = d;
               e.keep = k;
               e.last = l;
               pl_q.push_back(e);
               s     = {1'b0, m_cnt} + {1'b0, popcnt(k)};
               m_cnt = s[32] ? 32'hFFFF_FFFF : s[31:0];
               if (l) begin
                  m_hdr = 1'b1;
                  if (m_cnt != m_fs) err_q.push_back(acc_cyc);
               end
            end
         end
      end
      checks++;
      assert (acc) else begin
         failures++;
         $error("FAIL accept_timeout got=no_ready exp=accept");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic gap_check(input string tag, input int a, input int b);
      checks++;
      assert (b == a + 1) else begin
         failures++;
         $error("FAIL %s got=cycle%0d exp=cycle%0d", tag, b, a + 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, a3;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);

      // full frame, 128 bytes in two full beats, all ready
      send(rand_data(), KEEP_FULL, 1'b0, 32'd128, a0);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a1);
      send(rand_data(), KEEP_FULL, 1'b1, 32'd0, a2);
      gap_check("throughput_p1", a0, a1);
      gap_check("throughput_p2", a1, a2);
      idle(3);

      // partial last beat: 64 + 36 = 100 bytes, then the same frame against 96
      send(rand_data(), '0, 1'b0, 32'd100, a0);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a0);
      send(rand_data(), KEEP_36, 1'b1, 32'd0, a0);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd96, a1);
      gap_check("b2b_after_last", a0, a1);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a0);
      send(rand_data(), KEEP_36, 1'b1, 32'd0, a0);
      idle(3);

      // stalled outputs: payload ready toggles, MD ready low for 5 cycles after header
      tog_en = 1'b1;
      md_stall_until = cyc + 1000;
      send(rand_data(), KEEP_FULL, 1'b0, 32'd192, a0);
      md_stall_until = cyc + 5;
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a0);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a0);
      send(rand_data(), KEEP_FULL, 1'b1, 32'd0, a0);
      idle(10);
      tog_en = 1'b0;
      pl_ready_cfg = 1'b1;
      idle(3);

      // empty frame followed immediately by a 2-beat frame
      send(rand_data(), KEEP_FULL, 1'b1, 32'd0, a0);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd128, a1);
      gap_check("b2b_after_empty", a0, a1);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a2);
      send(rand_data(), KEEP_FULL, 1'b1, 32'd0, a3);
      gap_check("empty_next_p2", a2, a3);
      idle(3);

      // empty frame with nonzero size must flag an error
      send(rand_data(), KEEP_FULL, 1'b1, 32'd64, a0);
      idle(3);

      // reset mid-frame, then a fresh frame must start with a header
      send(rand_data(), KEEP_FULL, 1'b0, 32'd256, a0);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a0);
      reset = 1'b1;
      md_q.delete();
      pl_q.delete();
      err_q.delete();
      m_hdr = 1'b1;
      m_cnt = '0;
      idle(3);
      reset = 1'b0;
      idle(1);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd128, a0);
      send(rand_data(), KEEP_FULL, 1'b0, 32'd0, a0);
      send(rand_data(), KEEP_FULL, 1'b1, 32'd0, a0);
      idle(10);

      checks++;
      assert (md_q.size() == 0) else begin
         failures++;
         $error("FAIL md_drain got=%0d exp=0", md_q.size());
      end
      checks++;
      assert (pl_q.size() == 0) else begin
         failures++;
         $error("FAIL pl_drain got=%0d exp=0", pl_q.size());
      end
      checks++;
      assert (err_q.size() == 0) else begin
         failures++;
         $error("FAIL err_missing got=%0d exp=0", err_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
